// File: rtl/hid_rx_fifo_bank_pkg.sv
// Shared HID peripheral definitions: register offsets, status bit positions
// and the per-channel control register layout.
// Used by hid_rx_fifo_bank and hid_rx_fifo_chan.
package hid_periph_pkg;

  // Register offsets within a channel window, selected by hid_addr[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_CMD    = 2'd3;

  // STATUS and DATA bit positions
  localparam int unsigned ST_EMPTY       = 0;
  localparam int unsigned ST_FULL        = 1;
  localparam int unsigned ST_OVF         = 2;
  localparam int unsigned DATA_EMPTY_BIT = 31;

  // CTRL register contents
  typedef struct packed {
    logic [7:0] threshold;
    logic       ovf_irq_en;
    logic       irq_en;
  } ctrl_t;

endpackage

// File: rtl/hid_rx_fifo_bank_if.sv
// HID slave bus bundle for one data slot.
//   hid_en     : access strobe, already qualified by slot select
//   hid_we     : byte write enables (all zero = read)
//   hid_addr   : byte address, [7:4] channel, [3:2] register
//   hid_wrdata : write data
//   hid_rddata : registered read data from the slave
interface hid_rx_fifo_bank_if;
  logic        hid_en;
  logic [3:0]  hid_we;
  logic [7:0]  hid_addr;
  logic [31:0] hid_wrdata;
  logic [31:0] hid_rddata;

  modport master (output hid_en, hid_we, hid_addr, hid_wrdata, input hid_rddata);
  modport slave  (input hid_en, hid_we, hid_addr, hid_wrdata, output hid_rddata);
endinterface

// File: rtl/hid_rx_fifo_bank_chan.sv
// One receive FIFO channel: storage, pointers, occupancy count, sticky
// overflow, optional drop counter and the interrupt term.
// Optional feature macro: HID_RX_FIFO_DROPCNT_EN (16-bit saturating drop counter).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push_i/_data_i  : producer push strobe and data
//   pop_i           : pop request (ignored when empty)
//   flush_i         : empty the FIFO; wins over a same-cycle push
//   clr_ovf_i       : clear overflow (and drop counter when present)
//   ctrl_i          : threshold / interrupt enables
//   head_o, count_o, empty_o, full_o, ovf_o, dropcnt_o : channel state
//   irq_c           : interrupt term from current state (registered by the top)
module hid_rx_fifo_chan
  import hid_periph_pkg::*;
#(
  parameter  int unsigned DATA_W = 16,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic              clr_ovf_i,
  input  ctrl_t             ctrl_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              ovf_o,
  output logic [15:0]       dropcnt_o,
  output logic              irq_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d, ovf_q, ovf_d;
  logic              empty, do_push, do_pop, drop, thr_hit;

  assign empty = (count_q == '0);

  // Next-state: a pop frees a slot for a same-cycle push even when full
  always_comb begin
    do_pop   = pop_i & ~empty;
    do_push  = push_i & (~full_q | do_pop) & ~flush_i;
    drop     = push_i & full_q & ~do_pop & ~flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
    if (clr_ovf_i) ovf_d = 1'b0;
    if (drop)      ovf_d = 1'b1;
    full_d = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

`ifdef HID_RX_FIFO_DROPCNT_EN
  logic [15:0] dropcnt_q, dropcnt_d;

  // Saturating count of dropped pushes; a same-cycle clear counts the new drop
  always_comb begin
    dropcnt_d = dropcnt_q;
    if (clr_ovf_i) dropcnt_d = '0;
    if (drop && dropcnt_d != 16'hFFFF) dropcnt_d = dropcnt_d + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) dropcnt_q <= '0;
    else     dropcnt_q <= dropcnt_d;
  end

  assign dropcnt_o = dropcnt_q;
`else
  assign dropcnt_o = 16'h0000;
`endif

  // Thresholds above DEPTH can never be reached by count_q
  assign thr_hit = ctrl_i.irq_en & (ctrl_i.threshold != 8'd0) &
                   (16'(count_q) >= 16'(ctrl_i.threshold));
  assign irq_c   = thr_hit | (ctrl_i.ovf_irq_en & ovf_q);

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = empty;
  assign full_o  = full_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/hid_rx_fifo_bank.sv
// Memory-mapped bank of CHANNELS receive FIFOs in one HID data slot.
// Optional feature macro: HID_RX_FIFO_DROPCNT_EN (per-channel drop counter on CMD read).
// Ports:
//   hid_clk, hid_rst : clock, synchronous active-high reset
//   bus              : HID slave bus (hid_en/we/addr/wrdata in, hid_rddata out)
//   wr_valid/wr_data : per-channel producer pushes, channel c at [c*DATA_W +: DATA_W]
//   full             : per-channel full flag
//   irq, irq_any     : per-channel interrupt and their OR, registered
module hid_rx_fifo_bank
  import hid_periph_pkg::*;
#(
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned DATA_W   = 16,
  parameter  int unsigned DEPTH    = 16,
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                       hid_clk,
  input  logic                       hid_rst,
  hid_rx_fifo_bank_if.slave          bus,
  input  logic [CHANNELS-1:0]        wr_valid,
  input  logic [CHANNELS*DATA_W-1:0] wr_data,
  output logic [CHANNELS-1:0]        full,
  output logic [CHANNELS-1:0]        irq,
  output logic                       irq_any
);

  logic [3:0]          ch_idx;
  logic [1:0]          reg_sel;
  logic                rd_en, wr_en;
  logic [CHANNELS-1:0] sel, pop, flush, clr_ovf, empty, ovf, irq_c;
  logic [DATA_W-1:0]   head    [CHANNELS];
  logic [CNT_W-1:0]    count   [CHANNELS];
  logic [15:0]         dropcnt [CHANNELS];
  ctrl_t               ctrl_q  [CHANNELS];
  ctrl_t               ctrl_d  [CHANNELS];
  logic [31:0]         rddata_q, rddata_d;
  logic [CHANNELS-1:0] irq_q;
  logic                irq_any_q;
  logic                unused_bits;

  assign ch_idx      = bus.hid_addr[7:4];
  assign reg_sel     = bus.hid_addr[3:2];
  assign rd_en       = bus.hid_en & ~(|bus.hid_we);
  assign wr_en       = bus.hid_en &  (|bus.hid_we);
  assign unused_bits = ^{bus.hid_addr[1:0], bus.hid_wrdata[31:16], bus.hid_wrdata[7:2]};

  // Address decode; channels past CHANNELS match no sel bit
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      sel[c]     = (ch_idx == 4'(c));
      pop[c]     = rd_en & sel[c] & (reg_sel == REG_DATA);
      flush[c]   = wr_en & sel[c] & (reg_sel == REG_CMD) & bus.hid_wrdata[1];
      clr_ovf[c] = wr_en & sel[c] & (reg_sel == REG_CMD) & bus.hid_wrdata[0];
      ctrl_d[c]  = ctrl_q[c];
      if (wr_en && sel[c] && reg_sel == REG_CTRL) begin
        if (bus.hid_we[0]) begin
          ctrl_d[c].ovf_irq_en = bus.hid_wrdata[1];
          ctrl_d[c].irq_en     = bus.hid_wrdata[0];
        end
        if (bus.hid_we[1]) ctrl_d[c].threshold = bus.hid_wrdata[15:8];
      end
    end
  end

  // Read mux; DATA reports emptiness sampled before the pop
  always_comb begin
    rddata_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (sel[c]) begin
        case (reg_sel)
          REG_DATA: begin
            rddata_d[DATA_EMPTY_BIT] = empty[c];
            if (!empty[c]) rddata_d[DATA_W-1:0] = head[c];
          end
          REG_STATUS: begin
            rddata_d[31:16]    = 16'(count[c]);
            rddata_d[ST_OVF]   = ovf[c];
            rddata_d[ST_FULL]  = full[c];
            rddata_d[ST_EMPTY] = empty[c];
          end
          REG_CTRL: begin
            rddata_d[15:8] = ctrl_q[c].threshold;
            rddata_d[1]    = ctrl_q[c].ovf_irq_en;
            rddata_d[0]    = ctrl_q[c].irq_en;
          end
          default: rddata_d[15:0] = dropcnt[c];
        endcase
      end
    end
  end

  always_ff @(posedge hid_clk) begin
    if (hid_rst) begin
      rddata_q  <= '0;
      irq_q     <= '0;
      irq_any_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) ctrl_q[c] <= '0;
    end else begin
      if (rd_en) rddata_q <= rddata_d;
      irq_q     <= irq_c;
      irq_any_q <= |irq_c;
      for (int c = 0; c < CHANNELS; c++) ctrl_q[c] <= ctrl_d[c];
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    hid_rx_fifo_chan #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_chan (
      .clk         (hid_clk),
      .rst         (hid_rst),
      .push_i      (wr_valid[c]),
      .push_data_i (wr_data[c*DATA_W +: DATA_W]),
      .pop_i       (pop[c]),
      .flush_i     (flush[c]),
      .clr_ovf_i   (clr_ovf[c]),
      .ctrl_i      (ctrl_q[c]),
      .head_o      (head[c]),
      .count_o     (count[c]),
      .empty_o     (empty[c]),
      .full_o      (full[c]),
      .ovf_o       (ovf[c]),
      .dropcnt_o   (dropcnt[c]),
      .irq_c       (irq_c[c])
    );
  end

  assign bus.hid_rddata = rddata_q;
  assign irq            = irq_q;
  assign irq_any        = irq_any_q;

endmodule

// File: tb/tb_hid_rx_fifo_bank.sv
// Directed testbench for hid_rx_fifo_bank (CHANNELS=4, DATA_W=16, DEPTH=16).
// Expected CMD reads follow HID_RX_FIFO_DROPCNT_EN when defined.
module tb_hid_rx_fifo_bank;

  localparam int unsigned CH = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned DP = 16;

`ifdef HID_RX_FIFO_DROPCNT_EN
  localparam logic [31:0] EXP_DROP1 = 32'h0000_0001;
`else
  localparam logic [31:0] EXP_DROP1 = 32'h0000_0000;
`endif

  logic             hid_clk = 1'b0;
  logic             hid_rst = 1'b1;
  logic [CH-1:0]    wr_valid = '0;
  logic [CH*DW-1:0] wr_data = '0;
  logic [CH-1:0]    full, irq;
  logic             irq_any;
  logic [31:0]      rd;
  int               checks = 0;
  int               errors = 0;

  hid_rx_fifo_bank_if bus ();

  hid_rx_fifo_bank #(.CHANNELS(CH), .DATA_W(DW), .DEPTH(DP)) dut (
    .hid_clk  (hid_clk),
    .hid_rst  (hid_rst),
    .bus      (bus),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .full     (full),
    .irq      (irq),
    .irq_any  (irq_any)
  );

  always #5 hid_clk = ~hid_clk;

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge hid_clk);
    bus.hid_en = 1'b1; bus.hid_we = 4'h0; bus.hid_addr = a;
    @(posedge hid_clk); #1;
    d = bus.hid_rddata;
    bus.hid_en = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [3:0] we, input logic [31:0] d);
    @(negedge hid_clk);
    bus.hid_en = 1'b1; bus.hid_we = we; bus.hid_addr = a; bus.hid_wrdata = d;
    @(posedge hid_clk); #1;
    bus.hid_en = 1'b0; bus.hid_we = 4'h0;
  endtask

  task automatic push(input int ch, input logic [DW-1:0] d);
    @(negedge hid_clk);
    wr_valid[ch] = 1'b1; wr_data[ch*DW +: DW] = d;
    @(posedge hid_clk); #1;
    wr_valid = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge hid_clk);
    #1;
  endtask

  task automatic test_reset;
    bus.hid_en = 1'b0; bus.hid_we = 4'h0; bus.hid_addr = 8'h00; bus.hid_wrdata = 32'h0;
    hid_rst = 1'b1;
    idle(3);
    checks++; if (bus.hid_rddata !== 32'h0) begin errors++; $display("FAIL reset_rddata got %h exp %h", bus.hid_rddata, 32'h0); end
    checks++; if (irq !== 4'h0 || irq_any !== 1'b0) begin errors++; $display("FAIL reset_irq got %b/%b exp 0000/0", irq, irq_any); end
    checks++; if (full !== 4'h0) begin errors++; $display("FAIL reset_full got %b exp 0000", full); end
    @(negedge hid_clk); hid_rst = 1'b0;
    bus_read(8'h04, rd);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL reset_status got %h exp %h", rd, 32'h1); end
  endtask

  task automatic test_basic;
    push(0, 16'h1234);
    bus_read(8'h00, rd);
    checks++; if (rd !== 32'h0000_1234) begin errors++; $display("FAIL basic_data got %h exp %h", rd, 32'h1234); end
    bus_read(8'h04, rd);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL basic_status got %h exp %h", rd, 32'h1); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 17; i++) push(1, 16'(16'h0200 + i));
    checks++; if (full !== 4'b0010) begin errors++; $display("FAIL ovf_full got %b exp 0010", full); end
    bus_read(8'h14, rd);
    checks++; if (rd !== 32'h0010_0006) begin errors++; $display("FAIL ovf_status got %h exp %h", rd, 32'h0010_0006); end
    bus_read(8'h1C, rd);
    checks++; if (rd !== EXP_DROP1) begin errors++; $display("FAIL ovf_dropcnt got %h exp %h", rd, EXP_DROP1); end
    bus_write(8'h1C, 4'hF, 32'h1);
    bus_read(8'h14, rd);
    checks++; if (rd !== 32'h0010_0002) begin errors++; $display("FAIL ovf_clr_status got %h exp %h", rd, 32'h0010_0002); end
    bus_read(8'h1C, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ovf_clr_dropcnt got %h exp %h", rd, 32'h0); end
    bus_write(8'h1C, 4'hF, 32'h2);
    bus_read(8'h14, rd);
    checks++; if (rd !== 32'h0000_0001 || full !== 4'h0) begin errors++; $display("FAIL flush_status got %h/%b exp %h/0000", rd, full, 32'h1); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 16; i++) push(2, 16'(16'h0100 + i));
    // push and pop together on a full FIFO
    @(negedge hid_clk);
    bus.hid_en = 1'b1; bus.hid_we = 4'h0; bus.hid_addr = 8'h20;
    wr_valid[2] = 1'b1; wr_data[2*DW +: DW] = 16'hAAAA;
    @(posedge hid_clk); #1;
    rd = bus.hid_rddata; bus.hid_en = 1'b0; wr_valid = '0;
    checks++; if (rd !== 32'h0000_0100) begin errors++; $display("FAIL b2b_first got %h exp %h", rd, 32'h0100); end
    bus_read(8'h24, rd);
    checks++; if (rd !== 32'h0010_0002) begin errors++; $display("FAIL b2b_status got %h exp %h", rd, 32'h0010_0002); end
    for (int i = 1; i < 16; i++) begin
      bus_read(8'h20, rd);
      checks++; if (rd !== 32'(16'h0100 + i)) begin errors++; $display("FAIL b2b_drain%0d got %h exp %h", i, rd, 32'(16'h0100 + i)); end
    end
    bus_read(8'h20, rd);
    checks++; if (rd !== 32'h0000_AAAA) begin errors++; $display("FAIL b2b_last got %h exp %h", rd, 32'hAAAA); end
    bus_read(8'h20, rd);
    checks++; if (rd !== 32'h8000_0000) begin errors++; $display("FAIL b2b_empty got %h exp %h", rd, 32'h8000_0000); end
    // push and pop together on an empty FIFO
    @(negedge hid_clk);
    bus.hid_en = 1'b1; bus.hid_we = 4'h0; bus.hid_addr = 8'h20;
    wr_valid[2] = 1'b1; wr_data[2*DW +: DW] = 16'h5555;
    @(posedge hid_clk); #1;
    rd = bus.hid_rddata; bus.hid_en = 1'b0; wr_valid = '0;
    checks++; if (rd !== 32'h8000_0000) begin errors++; $display("FAIL b2b_empty_pop got %h exp %h", rd, 32'h8000_0000); end
    bus_read(8'h24, rd);
    checks++; if (rd !== 32'h0001_0000) begin errors++; $display("FAIL b2b_empty_status got %h exp %h", rd, 32'h0001_0000); end
    bus_read(8'h20, rd);
    checks++; if (rd !== 32'h0000_5555) begin errors++; $display("FAIL b2b_empty_data got %h exp %h", rd, 32'h5555); end
  endtask

  task automatic test_irq;
    bus_write(8'h38, 4'h3, 32'h0000_0401);
    bus_read(8'h38, rd);
    checks++; if (rd !== 32'h0000_0401) begin errors++; $display("FAIL irq_ctrl got %h exp %h", rd, 32'h0401); end
    for (int i = 0; i < 3; i++) push(3, 16'(16'h0031 + i));
    idle(2);
    checks++; if (irq !== 4'h0 || irq_any !== 1'b0) begin errors++; $display("FAIL irq_below got %b/%b exp 0000/0", irq, irq_any); end
    push(3, 16'h0034);
    idle(2);
    checks++; if (irq !== 4'b1000 || irq_any !== 1'b1) begin errors++; $display("FAIL irq_at_thr got %b/%b exp 1000/1", irq, irq_any); end
    bus_read(8'h30, rd);
    checks++; if (rd !== 32'h0000_0031) begin errors++; $display("FAIL irq_pop got %h exp %h", rd, 32'h31); end
    idle(2);
    checks++; if (irq !== 4'h0 || irq_any !== 1'b0) begin errors++; $display("FAIL irq_after_pop got %b/%b exp 0000/0", irq, irq_any); end
    // byte 0 only: threshold keeps 4, irq_en off, ovf_irq_en on
    bus_write(8'h38, 4'h1, 32'h0000_0002);
    bus_read(8'h38, rd);
    checks++; if (rd !== 32'h0000_0402) begin errors++; $display("FAIL irq_ctrl_byte got %h exp %h", rd, 32'h0402); end
    for (int i = 0; i < 14; i++) push(3, 16'(16'h0040 + i));
    idle(2);
    checks++; if (irq !== 4'b1000 || irq_any !== 1'b1) begin errors++; $display("FAIL irq_ovf got %b/%b exp 1000/1", irq, irq_any); end
    bus_write(8'h3C, 4'hF, 32'h1);
    idle(2);
    checks++; if (irq !== 4'h0) begin errors++; $display("FAIL irq_ovf_clr got %b exp 0000", irq); end
    bus_write(8'h38, 4'h3, 32'h0000_1101);
    idle(2);
    checks++; if (irq !== 4'h0) begin errors++; $display("FAIL irq_thr_gt_depth got %b exp 0000", irq); end
    bus_write(8'h3C, 4'hF, 32'h2);
    bus_read(8'h34, rd);
    checks++; if (rd !== 32'h0000_0001 || full !== 4'h0) begin errors++; $display("FAIL irq_flush got %h/%b exp %h/0000", rd, full, 32'h1); end
  endtask

  task automatic test_reset_mid;
    bus_write(8'h08, 4'h3, 32'h0000_0201);
    for (int i = 0; i < 5; i++) push(0, 16'(16'h0010 + i));
    idle(2);
    checks++; if (irq !== 4'b0001) begin errors++; $display("FAIL rmid_pre_irq got %b exp 0001", irq); end
    @(negedge hid_clk);
    bus.hid_en = 1'b1; bus.hid_we = 4'h0; bus.hid_addr = 8'h00; hid_rst = 1'b1;
    @(posedge hid_clk); #1;
    rd = bus.hid_rddata; bus.hid_en = 1'b0;
    @(negedge hid_clk); hid_rst = 1'b0;
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rmid_rddata got %h exp %h", rd, 32'h0); end
    bus_read(8'h04, rd);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL rmid_status got %h exp %h", rd, 32'h1); end
    idle(2);
    checks++; if (irq !== 4'h0 || irq_any !== 1'b0) begin errors++; $display("FAIL rmid_irq got %b/%b exp 0000/0", irq, irq_any); end
  endtask

  task automatic test_bad_channel;
    push(1, 16'h00A1);
    push(1, 16'h00A2);
    bus_write(8'h58, 4'hF, 32'hFFFF_FFFF);
    bus_write(8'h5C, 4'hF, 32'h0000_0003);
    bus_write(8'h50, 4'hF, 32'h1234_5678);
    for (int r = 0; r < 4; r++) begin
      bus_read(8'(8'h50 + 4 * r), rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL bad_ch_read%0d got %h exp %h", r, rd, 32'h0); end
    end
    bus_read(8'h14, rd);
    checks++; if (rd !== 32'h0002_0000) begin errors++; $display("FAIL bad_ch_status1 got %h exp %h", rd, 32'h0002_0000); end
    bus_read(8'h18, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL bad_ch_ctrl1 got %h exp %h", rd, 32'h0); end
    bus_read(8'h10, rd);
    checks++; if (rd !== 32'h0000_00A1) begin errors++; $display("FAIL bad_ch_data1 got %h exp %h", rd, 32'hA1); end
    idle(2);
    checks++; if (irq !== 4'h0) begin errors++; $display("FAIL bad_ch_irq got %b exp 0000", irq); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_irq();
    test_reset_mid();
    test_bad_channel();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hid_rx_fifo_bank.md
Name: hid_rx_fifo_bank

Overview:
- Parametrised, memory-mapped bank of CHANNELS independent receive FIFOs on the HID slave bus.
- Successor to the single fixed-width keyboard FIFO slot, with per-channel status, threshold/overflow interrupts and flush.
- Producers (PS/2 keyboard, mouse, UART RX, etc.) push into their own channel; software pops via the HID bus.
- Occupies one one-hot HID data slot; the slot select is decoded outside this block.

Parameters:
- CHANNELS, 4, number of FIFO channels (1..16).
- DATA_W, 16, bits per FIFO entry (1..30).
- DEPTH, 16, entries per channel; power of 2, 2..256.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridable).

Ports:
- hid_clk  in  1  single clock for all logic.
- hid_rst  in  1  reset; synchronous, active-high.
- hid_en  in  1  bus access strobe, already qualified with this block's slot select.
- hid_we  in  4  byte write enables; any bit set means write, all zero means read.
- hid_addr  in  8  byte address; [7:4] = channel, [3:2] = register.
- hid_wrdata  in  32  write data.
- hid_rddata  out  32  registered read data.
- wr_valid  in  CHANNELS  per-channel push strobe.
- wr_data  in  CHANNELS*DATA_W  per-channel push data; channel c occupies [c*DATA_W +: DATA_W].
- full  out  CHANNELS  per-channel full flag.
- irq  out  CHANNELS  per-channel interrupt, registered.
- irq_any  out  1  OR of irq, registered.

Behaviour:
- Reset (hid_clk edge with hid_rst=1):
  - all FIFOs empty, pointers 0;
  - overflow, irq_en, ovf_irq_en, threshold = 0;
  - hid_rddata = 0, irq = 0, irq_any = 0, full = 0.
- Reset asserted mid-operation discards all entries. A read in flight returns 0 the following cycle.
- Register map per channel, reg = hid_addr[3:2]:
  - 0 DATA, read: bit31 = empty (sampled before pop), [DATA_W-1:0] = head entry, other bits 0. A read while non-empty pops the entry. A read while empty returns 0x8000_0000 and pops nothing. Writes are ignored.
  - 1 STATUS, read-only: [31:16] = count (zero-extended), bit2 = overflow, bit1 = full, bit0 = empty.
  - 2 CTRL, read/write: [15:8] = threshold, bit1 = ovf_irq_en, bit0 = irq_en. Byte enables are honoured per byte.
  - 3 CMD, write: bit0 = 1 clears overflow, bit1 = 1 flushes the FIFO (pointers and count to 0). Read: see Optional Feature.
- Channel index >= CHANNELS: reads return 0, writes are ignored, nothing pops.
- Read latency: exactly 1 cycle. hid_rddata updates on the edge after the hid_en cycle and holds until the next read.
- Push: wr_valid[c] pushes when not full. Push while full drops the data and sets overflow (sticky).
- Simultaneous push and pop:
  - on a full FIFO: both succeed, count unchanged, no overflow;
  - on an empty FIFO: the pop sees empty (returns 0x8000_0000), the push succeeds, count becomes 1.
- Flush in the same cycle as a push: flush wins and the pushed data is dropped. Overflow is not set.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH. full = (count == DEPTH), registered with the count.
- Interrupt:
  - irq[c] next = (irq_en & threshold != 0 & count >= threshold) | (ovf_irq_en & overflow).
  - threshold values greater than DEPTH never fire.
  - irq_any next = |irq-next, so both update on the same edge.

Optional Feature:
- Macro: HID_RX_FIFO_DROPCNT_EN.
- Defined:
  - each channel keeps a 16-bit drop counter, incremented on every dropped push and saturating at 0xFFFF;
  - CMD read returns the count in [15:0];
  - a CMD write with bit0 = 1 clears both the drop counter and overflow.
- Undefined: no counter logic; CMD reads return 0.

Decomposition:
- Package hid_periph_pkg:
  - register offset constants REG_DATA=0, REG_STATUS=1, REG_CTRL=2, REG_CMD=3;
  - status bit positions ST_EMPTY=0, ST_FULL=1, ST_OVF=2, DATA_EMPTY_BIT=31;
  - typedef ctrl_t as a packed struct {threshold[7:0], ovf_irq_en, irq_en}.
- Sub-module hid_rx_fifo_chan:
  - one channel: storage, pointers, count, overflow, drop counter and the irq term;
  - instantiated CHANNELS times in a generate loop;
  - the top level does address decode and the registered read mux.

Test Plan:
- Reset, then push 0x1234 on channel 0 and read DATA (addr 0x00) -> hid_rddata = 0x0000_1234 one cycle later; STATUS read (0x04) -> 0x0000_0001.
- Push 17 entries into channel 1 (DEPTH=16) -> full[1]=1; STATUS (0x14) = 0x0010_0006; with the macro, CMD read (0x1C) = 1. Write CMD 0x1 -> overflow and drop count return to 0.
- Fill channel 2, then in one cycle assert push 0xAAAA and read DATA (0x20) -> first entry returned, count stays 16, no overflow; 16 more reads end with the last read returning 0xAAAA; the next read returns 0x8000_0000.
- CTRL ch3 (0x38) = 0x0000_0401, then push 3 entries -> irq[3]=0 and irq_any=0; 4th push -> irq[3]=irq_any=1 on the next edge; one pop -> both clear.
- Push 5 entries on ch0, assert hid_rst for 1 cycle mid-stream with a DATA read in flight -> rddata=0, STATUS=0x0000_0001, irq=0.
- Access channel 5 (CHANNELS=4, addr 0x50) -> reads return 0; writes have no effect on any channel.
